// File: rtl/spi_word_minion.sv
// rtl/spi_word_minion.sv - SPI mode-0 minion: one P_NBITS word per cs-low frame, push/pull word handshake
module spi_word_minion #(
  parameter int P_NBITS       = 32,
  parameter int P_SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               sclk,
  input  logic               mosi,
  output logic               miso,
  output logic [P_NBITS-1:0] push_msg,
  output logic               push_en,
  input  logic [P_NBITS-1:0] pull_msg,
  output logic               pull_en,
  output logic               parity,
  output logic               frame_err
);

  localparam int CW = $clog2(P_NBITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(P_NBITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(P_NBITS + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [P_SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                     cs_s, sclk_s, mosi_s;
  logic                     cs_h, sclk_h, mosi_h;
  logic                     cs_fall_q, cs_rise_q, sclk_rise_q, sclk_fall_q;
  logic [P_SYNC_STAGES:0]   prime;
  logic                     primed;

  logic [P_NBITS-1:0] tx_reg, rx_reg;
  logic [CW-1:0]      count;

  logic load_tx, rx_shift, tx_shift, frame_end;

  assign cs_s   = cs_sync[P_SYNC_STAGES-1];
  assign sclk_s = sclk_sync[P_SYNC_STAGES-1];
  assign mosi_s = mosi_sync[P_SYNC_STAGES-1];
  assign primed = prime[P_SYNC_STAGES];

  // Pin synchronisers, one history stage, and registered edge flags.
  // mosi_h lines up with sclk_rise_q so the sampled bit matches the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs_sync     <= '1;
      sclk_sync   <= '0;
      mosi_sync   <= '0;
      cs_h        <= 1'b1;
      sclk_h      <= 1'b0;
      mosi_h      <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      prime       <= '0;
    end else begin
      cs_sync     <= {cs_sync[P_SYNC_STAGES-2:0], cs};
      sclk_sync   <= {sclk_sync[P_SYNC_STAGES-2:0], sclk};
      mosi_sync   <= {mosi_sync[P_SYNC_STAGES-2:0], mosi};
      cs_h        <= cs_s;
      sclk_h      <= sclk_s;
      mosi_h      <= mosi_s;
      cs_fall_q   <= cs_h & ~cs_s;
      cs_rise_q   <= ~cs_h & cs_s;
      sclk_rise_q <= ~sclk_h & sclk_s;
      sclk_fall_q <= sclk_h & ~sclk_s;
      prime       <= {prime[P_SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // WAIT_IDLE holds until the synchroniser carries real pin samples and cs is high,
  // so a frame already in progress across reset is never picked up halfway.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (primed && cs_s) state_nxt = IDLE;
      IDLE:      if (cs_fall_q)      state_nxt = ACTIVE;
      ACTIVE:    if (cs_rise_q)      state_nxt = IDLE;
      default:                       state_nxt = WAIT_IDLE;
    endcase
  end

  always_comb begin
    load_tx   = 1'b0;
    rx_shift  = 1'b0;
    tx_shift  = 1'b0;
    frame_end = 1'b0;
    pull_en   = 1'b0;
    miso      = 1'b0;
    case (state)
      IDLE: begin
        load_tx = cs_fall_q;
        pull_en = cs_fall_q;
      end
      ACTIVE: begin
        miso      = tx_reg[P_NBITS-1];
        frame_end = cs_rise_q;
        rx_shift  = sclk_rise_q & ~cs_rise_q;
        tx_shift  = sclk_fall_q & ~cs_rise_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_reg    <= '0;
      rx_reg    <= '0;
      count     <= '0;
      push_msg  <= '0;
      push_en   <= 1'b0;
      parity    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_en   <= 1'b0;
      frame_err <= 1'b0;
      if (load_tx) begin
        tx_reg <= pull_msg;
        count  <= '0;
      end
      if (rx_shift) begin
        rx_reg <= {rx_reg[P_NBITS-2:0], mosi_h};
        if (count != CNT_SAT) count <= count + CW'(1);
      end
      if (tx_shift) begin
        tx_reg <= {tx_reg[P_NBITS-2:0], 1'b0};
      end
      if (frame_end) begin
        if (count == CNT_FULL) begin
          push_msg <= rx_reg;
          parity   <= ^rx_reg;
          push_en  <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule
